// File: rtl/mem_arbiter_if.sv
// Line request/response channel shared by the icache, dcache and memory sides of the arbiter.
// The requester drives the master modport; the responder drives the slave modport.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  req_valid;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [LINE_WIDTH-1:0] rsp_data;

  modport master (output req_valid, req_wr, req_addr, req_data, input rsp_valid, rsp_data);
  modport slave  (input req_valid, req_wr, req_addr, req_data, output rsp_valid, rsp_data);
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between icache and dcache line traffic to main memory.
// The dcache wins ties, bounded by a burst counter that forces an icache grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 128,
  parameter int DCACHE_BURST = 4
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave  icache,
  mem_arbiter_if.slave  dcache,
  mem_arbiter_if.master mem
);
  localparam int CNT_W = $clog2(DCACHE_BURST + 1);

  typedef enum logic [1:0] {IDLE, ICACHE_BUSY, DCACHE_BUSY} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
  } mem_req_t;

  state_t           state, state_nxt;
  mem_req_t         req_q;
  logic [CNT_W-1:0] dburst_cnt;
  logic             grant_i, grant_d, starve;

  assign starve = (dburst_cnt == CNT_W'(DCACHE_BURST));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // BUSY always returns through IDLE, which guarantees the one-cycle gap between transactions.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
        if (dcache.req_valid && !(icache.req_valid && starve)) begin
          grant_d   = 1'b1;
          state_nxt = DCACHE_BUSY;
        end else if (icache.req_valid) begin
          grant_i   = 1'b1;
          state_nxt = ICACHE_BUSY;
        end
      end
      ICACHE_BUSY, DCACHE_BUSY: if (mem.rsp_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.req_valid    = (state != IDLE);
    mem.req_wr       = req_q.wr;
    mem.req_addr     = req_q.addr;
    mem.req_data     = req_q.data;
    icache.rsp_valid = (state == ICACHE_BUSY) && mem.rsp_valid;
    dcache.rsp_valid = (state == DCACHE_BUSY) && mem.rsp_valid;
    icache.rsp_data  = mem.rsp_data;
    dcache.rsp_data  = mem.rsp_data;
  end

  // Captured request and starvation counter only move on an IDLE exit.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q      <= '0;
      dburst_cnt <= '0;
    end else if (grant_i) begin
      req_q      <= '{wr: 1'b0, addr: icache.req_addr, data: icache.req_data};
      dburst_cnt <= '0;
    end else if (grant_d) begin
      req_q <= '{wr: dcache.req_wr, addr: dcache.req_addr, data: dcache.req_data};
      if (!icache.req_valid)  dburst_cnt <= '0;
      else if (!starve)       dburst_cnt <= dburst_cnt + 1'b1;
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: line address width.
REQ-002 Parameter LINE_WIDTH, default 128: cache line data width.
REQ-003 Parameter DCACHE_BURST, default 4: maximum consecutive dcache grants while icache waits.
REQ-004 clock  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 icache_req_valid  in  1  icache miss request; held until icache_rsp_valid.
REQ-007 icache_req_addr  in  ADDR_WIDTH  icache miss line address.
REQ-008 icache_rsp_valid  out  1  one-cycle pulse; icache line returned.
REQ-009 icache_rsp_data  out  LINE_WIDTH  returned line.
REQ-010 dcache_req_valid  in  1  dcache request; held until dcache_rsp_valid.
REQ-011 dcache_req_wr  in  1  1 = writeback of a line, 0 = line fill.
REQ-012 dcache_req_addr  in  ADDR_WIDTH  dcache line address.
REQ-013 dcache_req_data  in  LINE_WIDTH  writeback data.
REQ-014 dcache_rsp_valid  out  1  one-cycle pulse; fill data returned or writeback acknowledged.
REQ-015 dcache_rsp_data  out  LINE_WIDTH  returned line (don't-care on writeback ack).
REQ-016 mem_req_valid  out  1  request to main memory; held until mem_rsp_valid.
REQ-017 mem_req_wr, mem_req_addr, mem_req_data  out  1/ADDR_WIDTH/LINE_WIDTH  registered copy of the granted request.
REQ-018 mem_rsp_valid, mem_rsp_data  in  1/LINE_WIDTH  memory completion pulse and fill data.

Function
REQ-019 FSM states: IDLE, ICACHE_BUSY, DCACHE_BUSY; exactly one transaction outstanding to memory at any time.
REQ-020 In IDLE with dcache_req_valid=1, next state DCACHE_BUSY, unless starvation guard (REQ-022) selects icache.
REQ-021 In IDLE with only icache_req_valid=1, next state ICACHE_BUSY.
REQ-022 Starvation guard: saturating counter dburst_cnt increments on each dcache grant while icache_req_valid=1, clears on every icache grant and on any dcache grant with icache_req_valid=0; when dburst_cnt==DCACHE_BURST and both request, icache is granted.
REQ-023 On grant (IDLE exit), mem_req_wr/addr/data are captured from the winner; mem_req_wr=0 for icache grants; mem_req_valid=1 from the cycle after the requester was sampled.
REQ-024 mem_req_valid and captured fields stay stable in the BUSY state until mem_rsp_valid=1.
REQ-025 In the cycle mem_rsp_valid=1 in ICACHE_BUSY: icache_rsp_valid=1, icache_rsp_data=mem_rsp_data (combinational pass-through); next state IDLE, mem_req_valid=0 next cycle.
REQ-026 Same for DCACHE_BUSY with dcache_rsp_valid/dcache_rsp_data.
REQ-027 IDLE is held for at least one cycle between transactions, so a requester that drops valid the cycle after its response is never re-granted.
REQ-028 mem_rsp_valid in IDLE is ignored; no rsp_valid is produced.
REQ-029 A requester deasserting valid while granted does not abort; the transaction completes and the response pulse is still produced.
REQ-030 icache_rsp_valid and dcache_rsp_valid are never both 1; the non-granted rsp_valid is always 0.
REQ-031 Minimum latency from request sampled in IDLE to rsp_valid = 1 + memory latency cycles, with memory latency >= 1.

Reset
REQ-032 When reset=1 at a clock edge: state=IDLE, dburst_cnt=0, mem_req_valid=0, mem_req_wr=0, mem_req_addr=0, mem_req_data=0.
REQ-033 While in IDLE after reset: icache_rsp_valid=0 and dcache_rsp_valid=0.
REQ-034 Reset asserted mid-transaction drops the outstanding transaction with no response pulse; any later mem_rsp_valid is ignored per REQ-028.

Verification
REQ-035 icache-only fill addr 0x40, memory latency 5: mem_req_valid rises 1 cycle later with wr=0, addr=0x40; icache_rsp_valid pulses for one cycle together with mem_rsp_valid; data matches.
REQ-036 icache and dcache request in the same cycle, both counters 0: dcache is granted first, icache is granted after the dcache response plus one IDLE cycle.
REQ-037 dcache requests continuously, icache pending, DCACHE_BURST=4: exactly 4 dcache grants, then an icache grant, then the counter is back at 0.
REQ-038 dcache writeback wr=1, addr 0x80, data 0xDEAD_BEEF...: mem_req_data matches; dcache_rsp_valid acks on mem_rsp_valid; icache_rsp_valid stays 0.
REQ-039 Reset asserted 2 cycles into a DCACHE_BUSY transaction, then mem_rsp_valid pulses: no rsp_valid on either port; mem_req_valid=0; next request is arbitrated normally.
REQ-040 Spurious mem_rsp_valid in IDLE: no rsp_valid, no state change.
